// File: rtl/spi_cmd_parser.sv
// Decodes the SPI receive byte stream into frame-buffer writes, channel-count updates and refresh strobes.
// All outputs are registered and appear one cycle after the byte that causes them. A CS deselect returns the parser to IDLE.
module spi_cmd_parser #(
   parameter int RAM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  spi_cs_in,
   input  logic                  byte_rdy_in,
   input  logic [7:0]            byte_data_in,
   output logic                  ram_wr_en_out,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr_out,
   output logic [7:0]            ram_wr_data_out,
   output logic [7:0]            chan_cnt_out,
   output logic                  flush_out,
   output logic                  ovf_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_CHAN, S_ADDR_H, S_ADDR_L, S_DATA, S_DROP
   } state_t;

   localparam logic [7:0]  CMD_SET_CHAN = 8'h2A;
   localparam logic [7:0]  CMD_WR_PIXEL = 8'h3C;
   localparam logic [7:0]  CMD_FLUSH    = 8'h5A;
   localparam logic [16:0] DEPTH_LIM    = 17'(RAM_DEPTH);

   state_t                state_q, state_d;
   logic [15:0]           addr_q, addr_d;
   logic [7:0]            addr_hi_q, addr_hi_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic [7:0]            chan_q, chan_d;
   logic                  flush_q, flush_d;
   logic                  ovf_q, ovf_d;
   logic                  in_range;

   // Widened compare so RAM_DEPTH up to 65536 is handled without truncation.
   assign in_range = ({1'b0, addr_q} < DEPTH_LIM);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      addr_hi_d = addr_hi_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      chan_d    = chan_q;
      flush_d   = 1'b0;
      ovf_d     = 1'b0;

      if (byte_rdy_in) begin
         case (state_q)
            S_IDLE: begin
               case (byte_data_in)
                  CMD_SET_CHAN: state_d = S_CHAN;
                  CMD_WR_PIXEL: state_d = S_ADDR_H;
                  CMD_FLUSH: begin
                     flush_d = 1'b1;
                     state_d = S_DROP;
                  end
                  default:      state_d = S_DROP;
               endcase
            end
            S_CHAN: begin
               chan_d  = byte_data_in;
               state_d = S_DROP;
            end
            S_ADDR_H: begin
               addr_hi_d = byte_data_in;
               state_d   = S_ADDR_L;
            end
            S_ADDR_L: begin
               addr_d  = {addr_hi_q, byte_data_in};
               state_d = S_DATA;
            end
            S_DATA: begin
               if (in_range) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = addr_q[ADDR_WIDTH-1:0];
                  wr_data_d = byte_data_in;
                  if (addr_q != 16'hFFFF) begin
                     addr_d = addr_q + 16'd1;
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
            default: state_d = S_DROP;
         endcase
      end

      // Deselect ends the frame after the coincident byte (if any) has been acted on.
      if (!spi_cs_in) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         addr_hi_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         chan_q    <= '0;
         flush_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         addr_hi_q <= addr_hi_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         chan_q    <= chan_d;
         flush_q   <= flush_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ram_wr_en_out   = wr_en_q;
   assign ram_wr_addr_out = wr_addr_q;
   assign ram_wr_data_out = wr_data_q;
   assign chan_cnt_out    = chan_q;
   assign flush_out       = flush_q;
   assign ovf_out         = ovf_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Bench for spi_cmd_parser: per-byte expected strobes are queued with their due cycle and matched on the falling edge.
module tb_spi_cmd_parser;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       spi_cs_in = 1'b0;
   logic       byte_rdy_in = 1'b0;
   logic [7:0] byte_data_in = 8'h00;
   logic       ram_wr_en_out;
   logic [9:0] ram_wr_addr_out;
   logic [7:0] ram_wr_data_out;
   logic [7:0] chan_cnt_out;
   logic       flush_out;
   logic       ovf_out;

   typedef struct {
      int         stamp;
      bit         wr;
      logic [9:0] addr;
      logic [7:0] data;
      bit         fl;
      bit         ov;
   } exp_t;

   exp_t exp_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   spi_cmd_parser #(.RAM_DEPTH(1024), .ADDR_WIDTH(10)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .spi_cs_in       (spi_cs_in),
      .byte_rdy_in     (byte_rdy_in),
      .byte_data_in    (byte_data_in),
      .ram_wr_en_out   (ram_wr_en_out),
      .ram_wr_addr_out (ram_wr_addr_out),
      .ram_wr_data_out (ram_wr_data_out),
      .chan_cnt_out    (chan_cnt_out),
      .flush_out       (flush_out),
      .ovf_out         (ovf_out)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Scoreboard: any strobe, or any expectation due this cycle, is compared here.
   exp_t mon_e;
   bit   mon_have;
   always @(negedge clk_in) begin
      while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_event stamp=%0d now=%0d: expected strobe never appeared", exp_q[0].stamp, cyc);
         void'(exp_q.pop_front());
      end
      mon_have = (exp_q.size() > 0 && exp_q[0].stamp == cyc);
      if (mon_have) mon_e = exp_q.pop_front();
      else          mon_e = '{stamp: cyc, wr: 1'b0, addr: 10'd0, data: 8'd0, fl: 1'b0, ov: 1'b0};
      if (mon_have || ram_wr_en_out || flush_out || ovf_out) begin
         checks++;
         if ({ram_wr_en_out, flush_out, ovf_out} !== {mon_e.wr, mon_e.fl, mon_e.ov} ||
             (mon_e.wr && (ram_wr_addr_out !== mon_e.addr || ram_wr_data_out !== mon_e.data))) begin
            errors++;
            $display("FAIL strobe cyc=%0d got wr=%b addr=%h data=%h fl=%b ov=%b want wr=%b addr=%h data=%h fl=%b ov=%b",
                     cyc, ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, flush_out, ovf_out,
                     mon_e.wr, mon_e.addr, mon_e.data, mon_e.fl, mon_e.ov);
         end
      end
   end

   // Presents one byte for a single cycle; expected effect is due one cycle later.
   task automatic send_byte(input logic [7:0] b, input bit wr, input logic [9:0] a,
                            input bit fl, input bit ov);
      @(negedge clk_in);
      byte_rdy_in  = 1'b1;
      byte_data_in = b;
      if (wr || fl || ov)
         exp_q.push_back('{stamp: cyc + 1, wr: wr, addr: a, data: b, fl: fl, ov: ov});
      @(posedge clk_in);
      #1;
      byte_rdy_in = 1'b0;
   endtask

   task automatic set_cs(input logic v);
      @(negedge clk_in);
      spi_cs_in = v;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic test_reset();
      idle_cycles(3);
      rst_in = 1'b0;
      idle_cycles(1);
      checks++;
      if ({ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, chan_cnt_out, flush_out, ovf_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got wr=%b addr=%h data=%h chan=%h fl=%b ov=%b want all zero",
                  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, chan_cnt_out, flush_out, ovf_out);
      end
   endtask

   task automatic test_write_burst();
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h00, 0, 10'h0, 0, 0);
      send_byte(8'h10, 0, 10'h0, 0, 0);
      send_byte(8'hAA, 1, 10'h010, 0, 0);
      send_byte(8'hBB, 1, 10'h011, 0, 0);
      send_byte(8'hCC, 1, 10'h012, 0, 0);
      set_cs(1'b0);
      idle_cycles(3);
      checks++;
      if (ram_wr_addr_out !== 10'h012 || ram_wr_data_out !== 8'hCC) begin
         errors++;
         $display("FAIL write_hold got addr=%h data=%h want addr=012 data=cc", ram_wr_addr_out, ram_wr_data_out);
      end
   endtask

   task automatic test_set_chan();
      set_cs(1'b1);
      send_byte(8'h2A, 0, 10'h0, 0, 0);
      send_byte(8'h18, 0, 10'h0, 0, 0);
      send_byte(8'h55, 0, 10'h0, 0, 0);
      set_cs(1'b0);
      idle_cycles(2);
      checks++;
      if (chan_cnt_out !== 8'h18) begin
         errors++;
         $display("FAIL set_chan got chan=%h want 18", chan_cnt_out);
      end
   endtask

   task automatic test_flush();
      set_cs(1'b1);
      send_byte(8'h5A, 0, 10'h0, 1, 0);
      send_byte(8'h5A, 0, 10'h0, 0, 0);
      set_cs(1'b0);
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h00, 0, 10'h0, 0, 0);
      send_byte(8'h00, 0, 10'h0, 0, 0);
      send_byte(8'h01, 1, 10'h000, 0, 0);
      set_cs(1'b0);
      idle_cycles(2);
   endtask

   task automatic test_overflow();
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h03, 0, 10'h0, 0, 0);
      send_byte(8'hFE, 0, 10'h0, 0, 0);
      send_byte(8'h11, 1, 10'h3FE, 0, 0);
      send_byte(8'h22, 1, 10'h3FF, 0, 0);
      send_byte(8'h33, 0, 10'h0, 0, 1);
      send_byte(8'h44, 0, 10'h0, 0, 1);
      set_cs(1'b0);
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'hFF, 0, 10'h0, 0, 0);
      send_byte(8'hFF, 0, 10'h0, 0, 0);
      send_byte(8'h66, 0, 10'h0, 0, 1);
      send_byte(8'h77, 0, 10'h0, 0, 1);
      set_cs(1'b0);
      idle_cycles(2);
      checks++;
      if (ram_wr_addr_out !== 10'h3FF || ram_wr_data_out !== 8'h22) begin
         errors++;
         $display("FAIL ovf_hold got addr=%h data=%h want addr=3ff data=22", ram_wr_addr_out, ram_wr_data_out);
      end
   endtask

   task automatic test_cs_abort();
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h00, 0, 10'h0, 0, 0);
      set_cs(1'b0);
      checks++;
      if (chan_cnt_out !== 8'h18) begin
         errors++;
         $display("FAIL abort_chan_kept got chan=%h want 18", chan_cnt_out);
      end
      set_cs(1'b1);
      send_byte(8'h2A, 0, 10'h0, 0, 0);
      send_byte(8'h07, 0, 10'h0, 0, 0);
      set_cs(1'b0);
      idle_cycles(1);
      checks++;
      if (chan_cnt_out !== 8'h07) begin
         errors++;
         $display("FAIL abort_chan got chan=%h want 07", chan_cnt_out);
      end
      // Deselect coincides with a data byte, then a byte arrives while still deselected.
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h01, 0, 10'h0, 0, 0);
      send_byte(8'h20, 0, 10'h0, 0, 0);
      spi_cs_in = 1'b0;
      send_byte(8'h44, 1, 10'h120, 0, 0);
      send_byte(8'h5A, 0, 10'h0, 1, 0);
      send_byte(8'h99, 0, 10'h0, 0, 0);
      idle_cycles(2);
   endtask

   task automatic test_back_to_back_reset();
      set_cs(1'b1);
      send_byte(8'h3C, 0, 10'h0, 0, 0);
      send_byte(8'h00, 0, 10'h0, 0, 0);
      send_byte(8'h10, 0, 10'h0, 0, 0);
      send_byte(8'hAA, 1, 10'h010, 0, 0);
      rst_in = 1'b1;
      send_byte(8'hBB, 0, 10'h0, 0, 0);
      rst_in = 1'b0;
      checks++;
      if ({ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, chan_cnt_out, flush_out, ovf_out} !== '0) begin
         errors++;
         $display("FAIL midcmd_reset got wr=%b addr=%h data=%h chan=%h fl=%b ov=%b want all zero",
                  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out, chan_cnt_out, flush_out, ovf_out);
      end
      send_byte(8'h2A, 0, 10'h0, 0, 0);
      send_byte(8'h05, 0, 10'h0, 0, 0);
      send_byte(8'hCC, 0, 10'h0, 0, 0);
      set_cs(1'b0);
      idle_cycles(1);
      checks++;
      if (chan_cnt_out !== 8'h05) begin
         errors++;
         $display("FAIL post_reset_cmd got chan=%h want 05", chan_cnt_out);
      end
   endtask

   initial begin
      test_reset();
      test_write_burst();
      test_set_chan();
      test_flush();
      test_overflow();
      test_cs_abort();
      test_back_to_back_reset();
      idle_cycles(3);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
